ahbl_arbiter2: RTL and testbench
================================

# ahbl_arbiter2

Two-master AHB-Lite arbiter that lets the Hazard2 CPU (M0) and a second bus master (M1, e.g. a DMA or accelerator) share the single AHB-Lite bus feeding `ahbl_splitter`. Each master's address phase is captured into a one-entry slot and stalled with its private HREADY. The arbiter then issues the captured transfers onto the shared bus, one owner per address phase, using round-robin or fixed priority. Neither master needs request/grant signalling; plain AHB-Lite masters connect directly.

## Interface
- `FIXED_PRIO`, default 0: 0 selects round-robin; 1 makes M0 always win simultaneous requests.
- `HCLK` input 1: bus clock; all state updates on its rising edge.
- `HRESETn` input 1: asynchronous active-low reset.
- `M0_HADDR`, `M1_HADDR` input 32: master address.
- `M0_HTRANS`, `M1_HTRANS` input 2: master transfer type. Bit 1 set means an active transfer (NONSEQ/SEQ).
- `M0_HSIZE`, `M1_HSIZE` input 3: master transfer size.
- `M0_HWRITE`, `M1_HWRITE` input 1: master write flag.
- `M0_HWDATA`, `M1_HWDATA` input 32: master write data. The master holds it valid through its data phase.
- `M0_HREADY`, `M1_HREADY` output 1: per-master ready or stall.
- `M0_HRDATA`, `M1_HRDATA` output 32: per-master read data.
- `HADDR` output 32: shared-bus address.
- `HTRANS` output 2: shared-bus transfer type.
- `HSIZE` output 3: shared-bus size.
- `HWRITE` output 1: shared-bus write flag.
- `HWDATA` output 32: shared-bus write data.
- `HREADY` input 1: shared-bus ready from the splitter.
- `HRDATA` input 32: shared-bus read data from the splitter.
- `HMASTER` output 1: owner of the current shared-bus address phase. Valid when `HTRANS[1]`=1.

## Operation

**Per-master slot.** Fields: `pend_v`, `addr`, `size`, `write`.
- Capture when `Mx_HREADY`=1 and `Mx_HTRANS[1]`=1.
- Cleared when the slot is issued, i.e. it is driven in a shared address phase with `HREADY`=1.

**Data-phase tracker.** Fields: `dph_v`, `dph_own`.
- Loaded on every shared address phase accepted with `HREADY`=1.
- Cleared when `HREADY`=1 and no new issue occurs.

**`Mx_HREADY` behaviour.**
- `Mx_HREADY` = 0 while `pend_v[x]`=1, or while the slot is issued and its data phase is outstanding.
- In the completing cycle (`dph_v`, `dph_own`=x, `HREADY`=1): `Mx_HREADY`=1 and `Mx_HRDATA`=`HRDATA`.
- Otherwise `Mx_HREADY`=1 and `Mx_HRDATA`=0. An idle master gets a zero-wait OKAY.

**Arbitration.** Evaluated every cycle over slots with `pend_v`=1 that are not yet issued.
- Only one candidate: that slot wins.
- Both candidates, `FIXED_PRIO`=0: the master other than `last_grant` wins.
- Both candidates, `FIXED_PRIO`=1: M0 wins.
- The winner drives `HADDR`/`HSIZE`/`HWRITE`/`HMASTER`, with `HTRANS`=2'b10 (SEQ is always converted to NONSEQ).
- `last_grant` updates only on an accepted issue (`HREADY`=1).
- If `HREADY`=0, the driven address phase is held stable, including the chosen owner. Arbitration does not re-run until acceptance.

**No candidate.** `HTRANS`=2'b00; `HADDR`/`HSIZE`/`HWRITE` hold their last values.

**Write data.** `HWDATA` = `dph_own` ? `M1_HWDATA` : `M0_HWDATA` while `dph_v`; 0 otherwise.

**Pipelining.** Address phase of one slot may overlap the data phase of the other master.

**Per-master throughput.** At most one outstanding transfer per master. A new capture cannot happen until that master's previous data phase completes.

## Timing
- **Reset values:** all slots empty, `dph_v`=0, `last_grant`=1 (M0 wins the first tie), `HTRANS`=0, `HADDR`=0, `HSIZE`=0, `HWRITE`=0, `HWDATA`=0, `HMASTER`=0, `Mx_HREADY`=1, `Mx_HRDATA`=0.
- **Uncontended latency:** capture in cycle t, shared address phase in t+1, data phase in t+2. With zero-wait slaves, `Mx_HREADY` returns to 1 in t+2, one cycle more than a direct connection.
- **Contended:** the loser's slot is issued in the first cycle after the winner's address phase is accepted.
- **Slave wait states:** extend the shared data phase, and also the stalled master's `Mx_HREADY`=0, one cycle each.
- **Reset mid-transfer:** asserted reset clears everything immediately and asynchronously. The in-flight transfer is dropped; no completion is reported to either master.

## Test plan
- **Single M0 read:** M0 NONSEQ read of 0x2000_0010, slave returns 0xDEADBEEF zero-wait -> `HTRANS`=2'b10, `HADDR`=0x2000_0010 in t+1; `M0_HREADY`=1 with `M0_HRDATA`=0xDEADBEEF in t+2.
- **Simultaneous requests, round-robin:** both masters request in the same cycle, `FIXED_PRIO`=0, after reset -> M0 is issued first, M1 the next cycle. Repeating both requests -> M0 then M1 again (alternation on ties).
- **Fixed priority:** `FIXED_PRIO`=1, M0 issues back-to-back reads while M1 is pending -> M1 is issued only in cycles where M0's slot is empty.
- **Wait states:** M1 write of 0x55AA to 0x4000_0000, slave inserts 2 wait states -> `HWDATA`=0x55AA held for 3 cycles; `M1_HREADY` is 0 until the third data-phase cycle; `HADDR` of an M0 transfer presented meanwhile is held stable.
- **SEQ conversion:** M1 drives SEQ -> shared `HTRANS`=2'b10.
- **Reset mid-data-phase:** `HRESETn` low during M0's data phase -> all outputs return to reset values within the same cycle.

Source files
------------

// File: rtl/ahbl_arbiter2.sv
// Two-master AHB-Lite arbiter: each master's address phase lands in a one-entry slot, and the slots share one bus.
// Latency: capture in t, shared address phase in t+1, data phase in t+2 (one cycle more than a direct connection).
// Backpressure: Mx_HREADY stalls a master while its slot is pending or its data phase waits on HREADY.
//
// Ports:
//   HCLK, HRESETn           clock, asynchronous active-low reset
//   M0_* / M1_*             plain AHB-Lite master ports (HADDR/HTRANS/HSIZE/HWRITE/HWDATA in, HREADY/HRDATA out)
//   HADDR..HWDATA, HMASTER  shared-bus address/data phase outputs toward the splitter
//   HREADY, HRDATA          shared-bus response from the splitter
module ahbl_arbiter2 #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        HCLK,
    input  logic        HRESETn,

    input  logic [31:0] M0_HADDR,
    input  logic [1:0]  M0_HTRANS,
    input  logic [2:0]  M0_HSIZE,
    input  logic        M0_HWRITE,
    input  logic [31:0] M0_HWDATA,
    output logic        M0_HREADY,
    output logic [31:0] M0_HRDATA,

    input  logic [31:0] M1_HADDR,
    input  logic [1:0]  M1_HTRANS,
    input  logic [2:0]  M1_HSIZE,
    input  logic        M1_HWRITE,
    input  logic [31:0] M1_HWDATA,
    output logic        M1_HREADY,
    output logic [31:0] M1_HRDATA,

    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HSIZE,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    output logic        HMASTER,
    input  logic        HREADY,
    input  logic [31:0] HRDATA
);

    // Per-master slots
    logic [1:0]  pend_v_q, pend_v_d;
    logic [31:0] addr0_q, addr1_q, addr0_d, addr1_d;
    logic [2:0]  size0_q, size1_q, size0_d, size1_d;
    logic        write0_q, write1_q, write0_d, write1_d;

    // Data-phase tracker
    logic        dph_v_q, dph_v_d;
    logic        dph_own_q, dph_own_d;

    // Arbitration state: last accepted owner, and the owner frozen while
    // HREADY=0 so a stalled address phase cannot change hands.
    logic        last_grant_q, last_grant_d;
    logic        lock_q, lock_d;
    logic        lock_own_q, lock_own_d;

    // Last driven address-phase fields, replayed while no slot is pending.
    logic [31:0] haddr_q, haddr_d;
    logic [2:0]  hsize_q, hsize_d;
    logic        hwrite_q, hwrite_d;
    logic        hmaster_q, hmaster_d;

    logic        any_cand;
    logic        win;
    logic        accept;
    logic [1:0]  m_ready;
    logic [1:0]  cap;

    // Only bit 1 of HTRANS matters: SEQ and NONSEQ are treated alike.
    logic unused_htrans;
    assign unused_htrans = M0_HTRANS[0] ^ M1_HTRANS[0];

    assign any_cand = |pend_v_q;
    assign accept   = any_cand & HREADY;

    always_comb begin
        win = hmaster_q;
        if (lock_q) begin
            win = lock_own_q;
        end else begin
            case (pend_v_q)
                2'b01:   win = 1'b0;
                2'b10:   win = 1'b1;
                2'b11:   win = FIXED_PRIO ? 1'b0 : ~last_grant_q;
                default: win = hmaster_q;
            endcase
        end
    end

    // Shared address phase
    assign HTRANS  = any_cand ? 2'b10 : 2'b00;
    assign HADDR   = any_cand ? (win ? addr1_q  : addr0_q)  : haddr_q;
    assign HSIZE   = any_cand ? (win ? size1_q  : size0_q)  : hsize_q;
    assign HWRITE  = any_cand ? (win ? write1_q : write0_q) : hwrite_q;
    assign HMASTER = any_cand ? win : hmaster_q;

    // Shared data phase: the owning master keeps its write data valid
    // because it is stalled until this phase completes.
    assign HWDATA = dph_v_q ? (dph_own_q ? M1_HWDATA : M0_HWDATA) : 32'h0;

    // Per-master response
    assign m_ready[0] = ~(pend_v_q[0] | (dph_v_q & ~dph_own_q & ~HREADY));
    assign m_ready[1] = ~(pend_v_q[1] | (dph_v_q &  dph_own_q & ~HREADY));
    assign M0_HREADY  = m_ready[0];
    assign M1_HREADY  = m_ready[1];
    assign M0_HRDATA  = (dph_v_q & ~dph_own_q & HREADY) ? HRDATA : 32'h0;
    assign M1_HRDATA  = (dph_v_q &  dph_own_q & HREADY) ? HRDATA : 32'h0;

    assign cap[0] = m_ready[0] & M0_HTRANS[1];
    assign cap[1] = m_ready[1] & M1_HTRANS[1];

    always_comb begin
        // Capture never coincides with issue of the same slot: capture needs
        // Mx_HREADY=1, which implies the slot is empty.
        pend_v_d[0] = cap[0] | (pend_v_q[0] & ~(accept & ~win));
        pend_v_d[1] = cap[1] | (pend_v_q[1] & ~(accept &  win));

        addr0_d  = cap[0] ? M0_HADDR  : addr0_q;
        size0_d  = cap[0] ? M0_HSIZE  : size0_q;
        write0_d = cap[0] ? M0_HWRITE : write0_q;
        addr1_d  = cap[1] ? M1_HADDR  : addr1_q;
        size1_d  = cap[1] ? M1_HSIZE  : size1_q;
        write1_d = cap[1] ? M1_HWRITE : write1_q;

        dph_v_d   = dph_v_q;
        dph_own_d = dph_own_q;
        if (HREADY) begin
            dph_v_d   = any_cand;
            dph_own_d = any_cand ? win : dph_own_q;
        end

        last_grant_d = accept ? win : last_grant_q;
        lock_d       = any_cand & ~HREADY;
        lock_own_d   = win;

        haddr_d   = HADDR;
        hsize_d   = HSIZE;
        hwrite_d  = HWRITE;
        hmaster_d = HMASTER;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_v_q     <= 2'b00;
            addr0_q      <= 32'h0;
            addr1_q      <= 32'h0;
            size0_q      <= 3'h0;
            size1_q      <= 3'h0;
            write0_q     <= 1'b0;
            write1_q     <= 1'b0;
            dph_v_q      <= 1'b0;
            dph_own_q    <= 1'b0;
            last_grant_q <= 1'b1;
            lock_q       <= 1'b0;
            lock_own_q   <= 1'b0;
            haddr_q      <= 32'h0;
            hsize_q      <= 3'h0;
            hwrite_q     <= 1'b0;
            hmaster_q    <= 1'b0;
        end else begin
            pend_v_q     <= pend_v_d;
            addr0_q      <= addr0_d;
            addr1_q      <= addr1_d;
            size0_q      <= size0_d;
            size1_q      <= size1_d;
            write0_q     <= write0_d;
            write1_q     <= write1_d;
            dph_v_q      <= dph_v_d;
            dph_own_q    <= dph_own_d;
            last_grant_q <= last_grant_d;
            lock_q       <= lock_d;
            lock_own_q   <= lock_own_d;
            haddr_q      <= haddr_d;
            hsize_q      <= hsize_d;
            hwrite_q     <= hwrite_d;
            hmaster_q    <= hmaster_d;
        end
    end

endmodule

// File: tb/tb_ahbl_arbiter2.sv
// Directed bench for ahbl_arbiter2: a round-robin instance and a fixed-priority instance share stimulus.
// Latency: each step is one HCLK cycle; outputs are sampled 2 time units after the rising edge.
// Backpressure: the bench plays both masters and the slave by hand, following the expected stalls.
module tb_ahbl_arbiter2;

    logic        HCLK = 1'b0;
    logic        HRESETn;

    logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata;
    logic [1:0]  m0_htrans, m1_htrans;
    logic [2:0]  m0_hsize, m1_hsize;
    logic        m0_hwrite, m1_hwrite;
    logic        hready;
    logic [31:0] hrdata;

    logic        r_m0_hready, r_m1_hready, r_hwrite, r_hmaster;
    logic [31:0] r_m0_hrdata, r_m1_hrdata, r_haddr, r_hwdata;
    logic [1:0]  r_htrans;
    logic [2:0]  r_hsize;

    logic        f_m0_hready, f_m1_hready, f_hwrite, f_hmaster;
    logic [31:0] f_m0_hrdata, f_m1_hrdata, f_haddr, f_hwdata;
    logic [1:0]  f_htrans;
    logic [2:0]  f_hsize;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 HCLK = ~HCLK;

    ahbl_arbiter2 #(.FIXED_PRIO(1'b0)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .M0_HADDR(m0_haddr), .M0_HTRANS(m0_htrans), .M0_HSIZE(m0_hsize),
        .M0_HWRITE(m0_hwrite), .M0_HWDATA(m0_hwdata),
        .M0_HREADY(r_m0_hready), .M0_HRDATA(r_m0_hrdata),
        .M1_HADDR(m1_haddr), .M1_HTRANS(m1_htrans), .M1_HSIZE(m1_hsize),
        .M1_HWRITE(m1_hwrite), .M1_HWDATA(m1_hwdata),
        .M1_HREADY(r_m1_hready), .M1_HRDATA(r_m1_hrdata),
        .HADDR(r_haddr), .HTRANS(r_htrans), .HSIZE(r_hsize), .HWRITE(r_hwrite),
        .HWDATA(r_hwdata), .HMASTER(r_hmaster), .HREADY(hready), .HRDATA(hrdata)
    );

    ahbl_arbiter2 #(.FIXED_PRIO(1'b1)) dut_fp (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .M0_HADDR(m0_haddr), .M0_HTRANS(m0_htrans), .M0_HSIZE(m0_hsize),
        .M0_HWRITE(m0_hwrite), .M0_HWDATA(m0_hwdata),
        .M0_HREADY(f_m0_hready), .M0_HRDATA(f_m0_hrdata),
        .M1_HADDR(m1_haddr), .M1_HTRANS(m1_htrans), .M1_HSIZE(m1_hsize),
        .M1_HWRITE(m1_hwrite), .M1_HWDATA(m1_hwdata),
        .M1_HREADY(f_m1_hready), .M1_HRDATA(f_m1_hrdata),
        .HADDR(f_haddr), .HTRANS(f_htrans), .HSIZE(f_hsize), .HWRITE(f_hwrite),
        .HWDATA(f_hwdata), .HMASTER(f_hmaster), .HREADY(hready), .HRDATA(hrdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_all();
        m0_haddr = 32'h0; m0_htrans = 2'b00; m0_hsize = 3'd0; m0_hwrite = 1'b0; m0_hwdata = 32'h0;
        m1_haddr = 32'h0; m1_htrans = 2'b00; m1_hsize = 3'd0; m1_hwrite = 1'b0; m1_hwdata = 32'h0;
        hready = 1'b1; hrdata = 32'h0;
    endtask

    task automatic m0_req(input logic [1:0] tr, input logic [31:0] a, input logic w);
        m0_htrans = tr; m0_haddr = a; m0_hwrite = w; m0_hsize = 3'd2;
    endtask

    task automatic m1_req(input logic [1:0] tr, input logic [31:0] a, input logic w);
        m1_htrans = tr; m1_haddr = a; m1_hwrite = w; m1_hsize = 3'd2;
    endtask

    task automatic do_reset();
        idle_all();
        HRESETn = 1'b0;
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_all();
        HRESETn = 1'b0;
        #2;
        // Reset state
        chk("rst_htrans",  r_htrans, 2'b00);
        chk("rst_haddr",   r_haddr, 32'h0);
        chk("rst_hsize",   r_hsize, 3'd0);
        chk("rst_hwrite",  r_hwrite, 1'b0);
        chk("rst_hwdata",  r_hwdata, 32'h0);
        chk("rst_hmaster", r_hmaster, 1'b0);
        chk("rst_m0_rdy",  r_m0_hready, 1'b1);
        chk("rst_m1_rdy",  r_m1_hready, 1'b1);
        chk("rst_m0_rd",   r_m0_hrdata, 32'h0);
        chk("rst_m1_rd",   r_m1_hrdata, 32'h0);
        do_reset();

        // Single M0 read
        m0_req(2'b10, 32'h2000_0010, 1'b0);
        settle(); chk("rd_cap_rdy", r_m0_hready, 1'b1);
        step();
        m0_htrans = 2'b00;
        settle();
        chk("rd_aph_htrans", r_htrans, 2'b10);
        chk("rd_aph_haddr", r_haddr, 32'h2000_0010);
        chk("rd_aph_hmaster", r_hmaster, 1'b0);
        chk("rd_aph_m0_rdy", r_m0_hready, 1'b0);
        step();
        hrdata = 32'hDEAD_BEEF;
        settle();
        chk("rd_dph_m0_rdy", r_m0_hready, 1'b1);
        chk("rd_dph_m0_rd", r_m0_hrdata, 32'hDEAD_BEEF);
        chk("rd_dph_m1_rd", r_m1_hrdata, 32'h0);
        chk("rd_dph_htrans", r_htrans, 2'b00);
        chk("rd_dph_haddr_hold", r_haddr, 32'h2000_0010);
        step();
        hrdata = 32'h0;
        do_reset();

        // Round-robin ties
        m0_req(2'b10, 32'h0000_1000, 1'b0);
        m1_req(2'b10, 32'h0000_2000, 1'b0);
        step();
        m0_htrans = 2'b00; m1_htrans = 2'b00;
        settle();
        chk("rr1_hmaster", r_hmaster, 1'b0);
        chk("rr1_haddr", r_haddr, 32'h0000_1000);
        chk("rr1_m1_rdy", r_m1_hready, 1'b0);
        step();
        hrdata = 32'h1111_1111;
        settle();
        chk("rr2_hmaster", r_hmaster, 1'b1);
        chk("rr2_haddr", r_haddr, 32'h0000_2000);
        chk("rr2_m0_rd", r_m0_hrdata, 32'h1111_1111);
        chk("rr2_m1_rdy", r_m1_hready, 1'b0);
        step();
        hrdata = 32'h2222_2222;
        m0_req(2'b10, 32'h0000_1004, 1'b0);
        m1_req(2'b10, 32'h0000_2004, 1'b0);
        settle();
        chk("rr3_m1_rdy", r_m1_hready, 1'b1);
        chk("rr3_m1_rd", r_m1_hrdata, 32'h2222_2222);
        chk("rr3_htrans", r_htrans, 2'b00);
        step();
        hrdata = 32'h0;
        m0_htrans = 2'b00; m1_htrans = 2'b00;
        settle();
        chk("rr4_hmaster", r_hmaster, 1'b0);
        chk("rr4_haddr", r_haddr, 32'h0000_1004);
        step();
        settle();
        chk("rr5_hmaster", r_hmaster, 1'b1);
        chk("rr5_haddr", r_haddr, 32'h0000_2004);
        step();
        // M0 alone, so the next tie must go to M1
        m0_req(2'b10, 32'h0000_1008, 1'b0);
        settle();
        chk("rr6_htrans", r_htrans, 2'b00);
        chk("rr6_haddr_hold", r_haddr, 32'h0000_2004);
        step();
        m0_htrans = 2'b00;
        settle();
        chk("rr7_hmaster", r_hmaster, 1'b0);
        step();
        m0_req(2'b10, 32'h0000_100C, 1'b0);
        m1_req(2'b10, 32'h0000_200C, 1'b0);
        settle();
        chk("rr8_m0_rdy", r_m0_hready, 1'b1);
        step();
        m0_htrans = 2'b00; m1_htrans = 2'b00;
        settle();
        chk("rr9_hmaster", r_hmaster, 1'b1);
        chk("rr9_haddr", r_haddr, 32'h0000_200C);
        step();
        settle();
        chk("rr10_hmaster", r_hmaster, 1'b0);
        chk("rr10_haddr", r_haddr, 32'h0000_100C);
        step();
        do_reset();

        // Fixed priority (dut_fp)
        m0_req(2'b10, 32'h0000_1000, 1'b0);
        step();
        m0_htrans = 2'b00;
        settle();
        chk("fp1_htrans", f_htrans, 2'b10);
        chk("fp1_hmaster", f_hmaster, 1'b0);
        step();
        m0_req(2'b10, 32'h0000_1010, 1'b0);
        m1_req(2'b10, 32'h0000_2010, 1'b0);
        settle();
        chk("fp2_m0_rdy", f_m0_hready, 1'b1);
        step();
        m0_htrans = 2'b00; m1_htrans = 2'b00;
        settle();
        chk("fp3_hmaster", f_hmaster, 1'b0);
        chk("fp3_haddr", f_haddr, 32'h0000_1010);
        chk("fp3_m1_rdy", f_m1_hready, 1'b0);
        step();
        m0_req(2'b10, 32'h0000_1020, 1'b0);
        settle();
        chk("fp4_hmaster", f_hmaster, 1'b1);
        chk("fp4_haddr", f_haddr, 32'h0000_2010);
        chk("fp4_m0_rdy", f_m0_hready, 1'b1);
        step();
        m0_htrans = 2'b00;
        settle();
        chk("fp5_hmaster", f_hmaster, 1'b0);
        chk("fp5_haddr", f_haddr, 32'h0000_1020);
        chk("fp5_m1_rdy", f_m1_hready, 1'b1);
        step();
        settle();
        chk("fp6_htrans", f_htrans, 2'b00);
        step();
        do_reset();

        // Wait states on an M1 write, M0 address held meanwhile
        m1_req(2'b10, 32'h4000_0000, 1'b1);
        step();
        m1_htrans = 2'b00;
        m1_hwdata = 32'h0000_55AA;
        m0_req(2'b10, 32'h0000_3000, 1'b0);
        settle();
        chk("ws1_hmaster", r_hmaster, 1'b1);
        chk("ws1_haddr", r_haddr, 32'h4000_0000);
        chk("ws1_hwrite", r_hwrite, 1'b1);
        step();
        m0_htrans = 2'b00;
        for (int i = 0; i < 3; i++) begin
            hready = (i == 2);
            settle();
            chk($sformatf("ws_dph%0d_hwdata", i), r_hwdata, 32'h0000_55AA);
            chk($sformatf("ws_dph%0d_m1_rdy", i), r_m1_hready, (i == 2));
            chk($sformatf("ws_dph%0d_haddr", i), r_haddr, 32'h0000_3000);
            chk($sformatf("ws_dph%0d_hmaster", i), r_hmaster, 1'b0);
            chk($sformatf("ws_dph%0d_m0_rdy", i), r_m0_hready, 1'b0);
            step();
        end
        hready = 1'b1;
        hrdata = 32'h3333_3333;
        settle();
        chk("ws_m0_rdy", r_m0_hready, 1'b1);
        chk("ws_m0_rd", r_m0_hrdata, 32'h3333_3333);
        chk("ws_m0_hwdata", r_hwdata, 32'h0);
        step();
        do_reset();

        // SEQ converted to NONSEQ
        m1_req(2'b11, 32'h0000_5000, 1'b0);
        step();
        m1_htrans = 2'b00;
        settle();
        chk("seq_htrans", r_htrans, 2'b10);
        chk("seq_hmaster", r_hmaster, 1'b1);
        step();
        do_reset();

        // Reset during M0's data phase, with M1 being issued
        m0_req(2'b10, 32'h0000_6000, 1'b0);
        m1_req(2'b10, 32'h0000_7000, 1'b1);
        step();
        m0_htrans = 2'b00; m1_htrans = 2'b00;
        settle();
        chk("mr_aph_hmaster", r_hmaster, 1'b0);
        step();
        hrdata = 32'h0000_AAAA;
        settle();
        chk("mr_pre_m0_rd", r_m0_hrdata, 32'h0000_AAAA);
        chk("mr_pre_hmaster", r_hmaster, 1'b1);
        HRESETn = 1'b0;
        #1;
        chk("mr_htrans", r_htrans, 2'b00);
        chk("mr_haddr", r_haddr, 32'h0);
        chk("mr_hwrite", r_hwrite, 1'b0);
        chk("mr_hmaster", r_hmaster, 1'b0);
        chk("mr_m0_rdy", r_m0_hready, 1'b1);
        chk("mr_m0_rd", r_m0_hrdata, 32'h0);
        chk("mr_m1_rdy", r_m1_hready, 1'b1);
        step();
        HRESETn = 1'b1;
        hrdata = 32'h0;
        settle();
        chk("mr_after_htrans", r_htrans, 2'b00);
        chk("mr_after_m1_rd", r_m1_hrdata, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
